// File: rtl/vx_dcache_arb_pkg.sv
// Shared types and helpers for the D$ request arbiter.
package vx_dcache_arb_pkg;

    typedef enum logic [0:0] {
        ArbIdle,
        ArbLocked
    } arb_state_e;

    // Number of client-index bits appended to the request tag.
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

endpackage

// File: rtl/vx_dcache_arb_rr.sv
// Round-robin priority search: first asserted request at or after rr_ptr_i, with wrap.
module vx_dcache_arb_rr #(
    parameter int NUM_REQS = 2,
    parameter int SEL_W    = 1
) (
    input  logic [NUM_REQS-1:0] req_i,
    input  logic [SEL_W-1:0]    rr_ptr_i,
    output logic [NUM_REQS-1:0] grant_onehot_o,
    output logic [SEL_W-1:0]    grant_idx_o,
    output logic                grant_valid_o
);

    int               idx;
    logic [SEL_W-1:0] pos;

    // Walk from the farthest candidate down so the closest hit to rr_ptr_i wins.
    always_comb begin
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        grant_valid_o  = 1'b0;
        idx            = 0;
        pos            = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_i) + k) % NUM_REQS;
            pos = SEL_W'(idx);
            if (req_i[pos]) begin
                grant_onehot_o      = '0;
                grant_onehot_o[pos] = 1'b1;
                grant_idx_o         = pos;
                grant_valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_dcache_arb.sv
// Shares one per-lane D$ request/response port between NUM_REQS clients; grant is held
// until every active lane of the granted request has been accepted.
module vx_dcache_arb
    import vx_dcache_arb_pkg::*;
#(
    parameter int NUM_REQS     = 2,
    parameter int NUM_LANES    = 4,
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_IN_WIDTH = 8
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0]                           req_valid_in,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0]                           req_rw_in,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][ADDR_WIDTH-1:0]           req_addr_in,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][DATA_WIDTH/8-1:0]         req_byteen_in,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][DATA_WIDTH-1:0]           req_data_in,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][TAG_IN_WIDTH-1:0]         req_tag_in,
    output logic [NUM_REQS-1:0][NUM_LANES-1:0]                           req_ready_in,
    output logic [NUM_LANES-1:0]                                         req_valid_out,
    output logic [NUM_LANES-1:0]                                         req_rw_out,
    output logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]                         req_addr_out,
    output logic [NUM_LANES-1:0][DATA_WIDTH/8-1:0]                       req_byteen_out,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]                         req_data_out,
    output logic [NUM_LANES-1:0][TAG_IN_WIDTH+sel_bits(NUM_REQS)-1:0]    req_tag_out,
    input  logic [NUM_LANES-1:0]                                         req_ready_out,
    input  logic                                                         rsp_valid_in,
    input  logic [NUM_LANES-1:0]                                         rsp_tmask_in,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]                         rsp_data_in,
    input  logic [TAG_IN_WIDTH+sel_bits(NUM_REQS)-1:0]                   rsp_tag_in,
    output logic                                                         rsp_ready_in,
    output logic [NUM_REQS-1:0]                                          rsp_valid_out,
    output logic [NUM_LANES-1:0]                                         rsp_tmask_out,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]                         rsp_data_out,
    output logic [TAG_IN_WIDTH-1:0]                                      rsp_tag_out,
    input  logic [NUM_REQS-1:0]                                          rsp_ready_out
);

    localparam int SelBits = sel_bits(NUM_REQS);
    localparam int TagOutW = TAG_IN_WIDTH + SelBits;

    always_comb begin
        rsp_tmask_out = reset ? '0 : rsp_tmask_in;
        rsp_data_out  = reset ? '0 : rsp_data_in;
    end

    if (NUM_REQS == 1) begin : g_pass

        always_comb begin
            req_valid_out   = reset ? '0 : req_valid_in[0];
            req_rw_out      = reset ? '0 : req_rw_in[0];
            req_addr_out    = reset ? '0 : req_addr_in[0];
            req_byteen_out  = reset ? '0 : req_byteen_in[0];
            req_data_out    = reset ? '0 : req_data_in[0];
            req_tag_out     = reset ? '0 : req_tag_in[0];
            req_ready_in[0] = reset ? '0 : req_ready_out;
            rsp_valid_out   = rsp_valid_in & ~reset;
            rsp_ready_in    = rsp_ready_out[0] & ~reset;
            rsp_tag_out     = reset ? '0 : rsp_tag_in;
        end

    end else begin : g_arb

        localparam logic [SelBits:0] NumReqsW = (SelBits + 1)'(NUM_REQS);

        arb_state_e           state_q, state_d;
        logic [SelBits-1:0]   rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
        logic [NUM_REQS-1:0]  active, arb_onehot, gnt_onehot;
        logic [SelBits-1:0]   arb_idx, gnt_idx, gnt_next, rsp_sel;
        logic                 arb_vld, gnt_vld, done, rsp_sel_ok;
        logic [NUM_LANES-1:0] fire;

        always_comb begin
            active = '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                active[i] = |req_valid_in[i];
            end
        end

        vx_dcache_arb_rr #(
            .NUM_REQS (NUM_REQS),
            .SEL_W    (SelBits)
        ) u_rr (
            .req_i          (active),
            .rr_ptr_i       (rr_ptr_q),
            .grant_onehot_o (arb_onehot),
            .grant_idx_o    (arb_idx),
            .grant_valid_o  (arb_vld)
        );

        // While locked the owner is fixed; other clients are not even looked at.
        always_comb begin
            gnt_onehot = '0;
            if (state_q == ArbLocked) begin
                gnt_idx                = lock_idx_q;
                gnt_onehot[lock_idx_q] = 1'b1;
                gnt_vld                = 1'b1;
            end else begin
                gnt_idx    = arb_idx;
                gnt_onehot = arb_onehot;
                gnt_vld    = arb_vld;
            end
            if (reset) begin
                gnt_onehot = '0;
                gnt_vld    = 1'b0;
            end
        end

        always_comb begin
            req_valid_out  = '0;
            req_rw_out     = '0;
            req_addr_out   = '0;
            req_byteen_out = '0;
            req_data_out   = '0;
            req_tag_out    = '0;
            if (gnt_vld) begin
                req_valid_out  = req_valid_in[gnt_idx];
                req_rw_out     = req_rw_in[gnt_idx];
                req_addr_out   = req_addr_in[gnt_idx];
                req_byteen_out = req_byteen_in[gnt_idx];
                req_data_out   = req_data_in[gnt_idx];
                for (int l = 0; l < NUM_LANES; l++) begin
                    req_tag_out[l] = {req_tag_in[gnt_idx][l], gnt_idx};
                end
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                req_ready_in[i] = gnt_onehot[i] ? req_ready_out : '0;
            end
        end

        always_comb begin
            fire       = req_valid_out & req_ready_out;
            done       = (req_valid_in[gnt_idx] & ~fire) == '0;
            gnt_next   = (gnt_idx == SelBits'(NUM_REQS - 1)) ? '0 : gnt_idx + SelBits'(1);
            state_d    = state_q;
            rr_ptr_d   = rr_ptr_q;
            lock_idx_d = lock_idx_q;
            if (gnt_vld) begin
                unique case (state_q)
                    ArbIdle: begin
                        if (done) begin
                            rr_ptr_d = gnt_next;
                        end else begin
                            state_d    = ArbLocked;
                            lock_idx_d = gnt_idx;
                        end
                    end
                    ArbLocked: begin
                        if (done) begin
                            state_d  = ArbIdle;
                            rr_ptr_d = gnt_next;
                        end
                    end
                    default: state_d = ArbIdle;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q    <= ArbIdle;
                rr_ptr_q   <= '0;
                lock_idx_q <= '0;
            end else begin
                state_q    <= state_d;
                rr_ptr_q   <= rr_ptr_d;
                lock_idx_q <= lock_idx_d;
            end
        end

        // Out-of-range client index: drop the response by accepting it.
        always_comb begin
            rsp_sel       = rsp_tag_in[SelBits-1:0];
            rsp_sel_ok    = {1'b0, rsp_sel} < NumReqsW;
            rsp_valid_out = '0;
            rsp_ready_in  = 1'b0;
            rsp_tag_out   = '0;
            if (!reset) begin
                rsp_tag_out = rsp_tag_in[TagOutW-1:SelBits];
                if (rsp_sel_ok) begin
                    rsp_valid_out[rsp_sel] = rsp_valid_in;
                    rsp_ready_in           = rsp_ready_out[rsp_sel];
                end else begin
                    rsp_ready_in = 1'b1;
                end
            end
        end

        a_rsp_sel_legal: assert property (@(posedge clk) disable iff (reset)
            rsp_valid_in |-> rsp_sel_ok);

    end

endmodule

// File: tb/tb_vx_dcache_arb.sv
// Randomized scoreboard bench for vx_dcache_arb, plus a NUM_REQS=1 pass-through instance.
module tb_vx_dcache_arb;

    localparam int NR  = 2;
    localparam int NL  = 4;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TW  = 8;
    localparam int SB  = 1;
    localparam int TOW = TW + SB;

    typedef struct packed {
        logic [NL-1:0]         mask;
        logic [NL-1:0]         rw;
        logic [NL-1:0][AW-1:0] addr;
        logic [NL-1:0][BW-1:0] be;
        logic [NL-1:0][DW-1:0] data;
        logic [NL-1:0][TW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [NR-1:0]         vld;
        logic [TW-1:0]         tag;
        logic [NL-1:0]         tmask;
        logic [NL-1:0][DW-1:0] data;
        logic                  rdy;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;

    logic [NR-1:0][NL-1:0]         req_valid_in, req_rw_in, req_ready_in;
    logic [NR-1:0][NL-1:0][AW-1:0] req_addr_in;
    logic [NR-1:0][NL-1:0][BW-1:0] req_byteen_in;
    logic [NR-1:0][NL-1:0][DW-1:0] req_data_in;
    logic [NR-1:0][NL-1:0][TW-1:0] req_tag_in;
    logic [NL-1:0]                 req_valid_out, req_rw_out, req_ready_out;
    logic [NL-1:0][AW-1:0]         req_addr_out;
    logic [NL-1:0][BW-1:0]         req_byteen_out;
    logic [NL-1:0][DW-1:0]         req_data_out;
    logic [NL-1:0][TOW-1:0]        req_tag_out;
    logic                          rsp_valid_in, rsp_ready_in;
    logic [NL-1:0]                 rsp_tmask_in, rsp_tmask_out;
    logic [NL-1:0][DW-1:0]         rsp_data_in, rsp_data_out;
    logic [TOW-1:0]                rsp_tag_in;
    logic [NR-1:0]                 rsp_valid_out, rsp_ready_out;
    logic [TW-1:0]                 rsp_tag_out;

    logic [0:0][NL-1:0]            p1_req_valid_in, p1_req_rw_in, p1_req_ready_in;
    logic [0:0][NL-1:0][AW-1:0]    p1_req_addr_in;
    logic [0:0][NL-1:0][BW-1:0]    p1_req_byteen_in;
    logic [0:0][NL-1:0][DW-1:0]    p1_req_data_in;
    logic [0:0][NL-1:0][TW-1:0]    p1_req_tag_in;
    logic [NL-1:0]                 p1_req_valid_out, p1_req_rw_out, p1_req_ready_out;
    logic [NL-1:0][AW-1:0]         p1_req_addr_out;
    logic [NL-1:0][BW-1:0]         p1_req_byteen_out;
    logic [NL-1:0][DW-1:0]         p1_req_data_out;
    logic [NL-1:0][TW-1:0]         p1_req_tag_out;
    logic                          p1_rsp_valid_in, p1_rsp_ready_in;
    logic [NL-1:0]                 p1_rsp_tmask_in, p1_rsp_tmask_out;
    logic [NL-1:0][DW-1:0]         p1_rsp_data_in, p1_rsp_data_out;
    logic [TW-1:0]                 p1_rsp_tag_in, p1_rsp_tag_out;
    logic [0:0]                    p1_rsp_valid_out, p1_rsp_ready_out;

    vx_dcache_arb #(
        .NUM_REQS(NR), .NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
        .req_byteen_in(req_byteen_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_in(req_ready_in),
        .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_addr_out(req_addr_out),
        .req_byteen_out(req_byteen_out), .req_data_out(req_data_out),
        .req_tag_out(req_tag_out), .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_tmask_in(rsp_tmask_in), .rsp_data_in(rsp_data_in),
        .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_tmask_out(rsp_tmask_out),
        .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out)
    );

    vx_dcache_arb #(
        .NUM_REQS(1), .NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)
    ) dut1 (
        .clk(clk), .reset(reset),
        .req_valid_in(p1_req_valid_in), .req_rw_in(p1_req_rw_in),
        .req_addr_in(p1_req_addr_in), .req_byteen_in(p1_req_byteen_in),
        .req_data_in(p1_req_data_in), .req_tag_in(p1_req_tag_in),
        .req_ready_in(p1_req_ready_in),
        .req_valid_out(p1_req_valid_out), .req_rw_out(p1_req_rw_out),
        .req_addr_out(p1_req_addr_out), .req_byteen_out(p1_req_byteen_out),
        .req_data_out(p1_req_data_out), .req_tag_out(p1_req_tag_out),
        .req_ready_out(p1_req_ready_out),
        .rsp_valid_in(p1_rsp_valid_in), .rsp_tmask_in(p1_rsp_tmask_in),
        .rsp_data_in(p1_rsp_data_in), .rsp_tag_in(p1_rsp_tag_in),
        .rsp_ready_in(p1_rsp_ready_in),
        .rsp_valid_out(p1_rsp_valid_out), .rsp_tmask_out(p1_rsp_tmask_out),
        .rsp_data_out(p1_rsp_data_out), .rsp_tag_out(p1_rsp_tag_out),
        .rsp_ready_out(p1_rsp_ready_out)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    req_t exp_q[NR][$];
    rsp_t rsp_q[$];

    task automatic chk(input string name, input logic [511:0] act_v, input logic [511:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h @%0t", name, act_v, exp_v, $time);
        end
    endtask

    // Client side: lanes accepted this cycle are dropped after the next edge.
    logic [NR-1:0][NL-1:0] acc;
    always @(negedge clk) acc = req_ready_in & req_valid_in;

    // Reference model: one owner at a time, chosen round-robin among clients with pending work.
    int                    owner = -1;
    int                    ptr   = 0;
    logic [NL-1:0]         fired [NR];
    logic [NL-1:0]         mon_ev, mon_fire;
    logic [NR-1:0][NL-1:0] mon_rdy;
    logic [SB-1:0]         mon_ob;
    req_t                  mon_h;
    rsp_t                  mon_r;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs",
                {req_valid_out, req_rw_out, req_addr_out, req_byteen_out, req_data_out,
                 req_tag_out, req_ready_in, rsp_valid_out, rsp_ready_in, rsp_tmask_out,
                 rsp_data_out, rsp_tag_out}, '0);
            owner = -1;
            ptr   = 0;
            for (int c = 0; c < NR; c++) fired[c] = '0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (owner < 0 && exp_q[(ptr + k) % NR].size() > 0) owner = (ptr + k) % NR;
            end
            mon_ev  = '0;
            mon_rdy = '0;
            if (owner >= 0) begin
                mon_h          = exp_q[owner][0];
                mon_ev         = mon_h.mask & ~fired[owner];
                mon_rdy[owner] = req_ready_out;
            end
            chk("req_valid_out", req_valid_out, mon_ev);
            chk("req_ready_in", req_ready_in, mon_rdy);
            if (owner >= 0) begin
                mon_fire = mon_ev & req_ready_out;
                mon_ob   = SB'(owner);
                for (int l = 0; l < NL; l++) begin
                    if (mon_fire[l]) begin
                        chk("lane_payload",
                            {req_rw_out[l], req_addr_out[l], req_byteen_out[l],
                             req_data_out[l], req_tag_out[l]},
                            {mon_h.rw[l], mon_h.addr[l], mon_h.be[l], mon_h.data[l],
                             mon_h.tag[l], mon_ob});
                    end
                end
                fired[owner] = fired[owner] | mon_fire;
                if ((mon_h.mask & ~fired[owner]) == '0) begin
                    void'(exp_q[owner].pop_front());
                    fired[owner] = '0;
                    ptr          = (owner + 1) % NR;
                    owner        = -1;
                end
            end
            if (rsp_q.size() > 0 || rsp_valid_out != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid_out, '0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rsp_route",
                        {rsp_valid_out, rsp_tag_out, rsp_tmask_out, rsp_data_out, rsp_ready_in},
                        mon_r);
                end
            end
        end
    end

    task automatic issue(input int c, input logic [NL-1:0] m);
        req_t r;
        r.mask = m;
        for (int l = 0; l < NL; l++) begin
            r.rw[l]   = 1'($urandom);
            r.addr[l] = AW'($urandom);
            r.be[l]   = BW'($urandom);
            r.data[l] = $urandom;
            r.tag[l]  = TW'($urandom);
        end
        req_valid_in[c]  = m;
        req_rw_in[c]     = r.rw;
        req_addr_in[c]   = r.addr;
        req_byteen_in[c] = r.be;
        req_data_in[c]   = r.data;
        req_tag_in[c]    = r.tag;
        exp_q[c].push_back(r);
    endtask

    task automatic send_rsp(input logic [TOW-1:0] tag, input logic [NR-1:0] rdy);
        rsp_t e;
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = tag;
        rsp_tmask_in  = NL'($urandom);
        for (int l = 0; l < NL; l++) rsp_data_in[l] = $urandom;
        rsp_ready_out = rdy;
        e.vld         = '0;
        e.vld[tag[0]] = 1'b1;
        e.tag         = tag[TOW-1:1];
        e.tmask       = rsp_tmask_in;
        e.data        = rsp_data_in;
        e.rdy         = rdy[tag[0]];
        rsp_q.push_back(e);
    endtask

    task automatic cycle(input bit rnd_rdy, input bit rnd_issue, input bit rnd_rsp);
        @(posedge clk);
        #1;
        for (int c = 0; c < NR; c++) req_valid_in[c] = req_valid_in[c] & ~acc[c];
        rsp_valid_in = 1'b0;
        if (rnd_rdy) req_ready_out = NL'($urandom);
        if (rnd_issue) begin
            for (int c = 0; c < NR; c++) begin
                if (req_valid_in[c] == '0 && $urandom_range(0, 1) == 1)
                    issue(c, NL'($urandom_range(1, (1 << NL) - 1)));
            end
        end
        if (rnd_rsp && $urandom_range(0, 1) == 1) send_rsp(TOW'($urandom), NR'($urandom));
    endtask

    task automatic drain();
        req_ready_out = '1;
        for (int i = 0; i < 200 && (exp_q[0].size() + exp_q[1].size()) > 0; i++) cycle(0, 0, 0);
        chk("drain_empty", exp_q[0].size() + exp_q[1].size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid_in = '0; req_rw_in = '0; req_addr_in = '0; req_byteen_in = '0;
        req_data_in = '0; req_tag_in = '0; req_ready_out = '0;
        rsp_valid_in = 1'b0; rsp_tmask_in = '0; rsp_data_in = '0; rsp_tag_in = '0;
        rsp_ready_out = '0;
        p1_req_valid_in = '0; p1_req_rw_in = '0; p1_req_addr_in = '0; p1_req_byteen_in = '0;
        p1_req_data_in = '0; p1_req_tag_in = '0; p1_req_ready_out = '0;
        p1_rsp_valid_in = 1'b0; p1_rsp_tmask_in = '0; p1_rsp_data_in = '0;
        p1_rsp_tag_in = '0; p1_rsp_ready_out = '0;
        repeat (3) cycle(0, 0, 0);
        reset = 1'b0;

        // Client 0 locked across two partial-accept cycles while client 1 waits.
        issue(0, 4'hF);
        issue(1, 4'h5);
        req_ready_out = 4'b0011;
        cycle(0, 0, 0);
        req_ready_out = 4'b1100;
        cycle(0, 0, 0);
        req_ready_out = 4'b1111;
        repeat (2) cycle(0, 0, 0);

        // Single client, full readiness: one-cycle completion.
        issue(0, 4'hF);
        cycle(0, 0, 0);

        // Response routing: client 1 not ready, then client 0.
        send_rsp({8'hA5, 1'b1}, 2'b01);
        cycle(0, 0, 0);
        send_rsp({8'h3C, 1'b0}, 2'b01);
        cycle(0, 0, 0);

        // Both clients continuously active with full readiness.
        req_ready_out = '1;
        for (int it = 0; it < 9; it++) begin
            for (int c = 0; c < NR; c++) if (req_valid_in[c] == '0) issue(c, 4'hF);
            cycle(0, 0, 0);
        end
        drain();

        for (int i = 0; i < 2000; i++) cycle(1, 1, 1);
        cycle(0, 0, 0);
        drain();

        // Reset while locked on client 1.
        issue(1, 4'hF);
        req_ready_out = 4'b0001;
        cycle(0, 0, 0);
        reset           = 1'b1;
        req_ready_out   = '1;
        req_valid_in[0] = 4'hF;
        rsp_valid_in    = 1'b1;
        rsp_tmask_in    = 4'hF;
        rsp_ready_out   = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        req_valid_in = '0;
        rsp_valid_in = 1'b0;
        for (int c = 0; c < NR; c++) exp_q[c].delete();
        issue(0, 4'hF);
        issue(1, 4'hF);
        repeat (3) cycle(0, 0, 0);
        drain();

        // NUM_REQS=1 pass-through.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #3;
            p1_req_valid_in  = NL'($urandom);
            p1_req_rw_in     = NL'($urandom);
            p1_req_ready_out = NL'($urandom);
            for (int l = 0; l < NL; l++) begin
                p1_req_addr_in[0][l]   = AW'($urandom);
                p1_req_byteen_in[0][l] = BW'($urandom);
                p1_req_data_in[0][l]   = $urandom;
                p1_req_tag_in[0][l]    = TW'($urandom);
                p1_rsp_data_in[l]      = $urandom;
            end
            p1_rsp_valid_in  = 1'($urandom);
            p1_rsp_ready_out = 1'($urandom);
            p1_rsp_tmask_in  = NL'($urandom);
            p1_rsp_tag_in    = TW'($urandom);
            #1;
            chk("p1_req",
                {p1_req_valid_out, p1_req_rw_out, p1_req_addr_out, p1_req_byteen_out,
                 p1_req_data_out, p1_req_tag_out},
                {p1_req_valid_in[0], p1_req_rw_in[0], p1_req_addr_in[0], p1_req_byteen_in[0],
                 p1_req_data_in[0], p1_req_tag_in[0]});
            chk("p1_ready", p1_req_ready_in, p1_req_ready_out);
            chk("p1_rsp",
                {p1_rsp_valid_out, p1_rsp_ready_in, p1_rsp_tag_out, p1_rsp_tmask_out,
                 p1_rsp_data_out},
                {p1_rsp_valid_in, p1_rsp_ready_out, p1_rsp_tag_in, p1_rsp_tmask_in,
                 p1_rsp_data_in});
        end

        @(posedge clk);
        #1;
        chk("rsp_queue_empty", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_dcache_arb.md
# VX_dcache_arb

Per-lane request arbiter that shares the core's single D$ request/response port between several memory clients, for example the LSU and a hardware prefetch engine.
- It grants one client at a time, round-robin. The grant stays locked until every active lane of that client's request has been accepted, because the cache back-pressures each lane independently.
- It appends the client index to the request tag, and uses that index to route each D$ response back to its owner.
- It sits between the clients and the D$ request/response ports.

## Interface
Parameters:
- NUM_REQS, 2, number of clients (≥1)
- NUM_LANES, 4, lanes per request (= NUM_THREADS)
- ADDR_WIDTH, 30, word address width
- DATA_WIDTH, 32, lane data width
- TAG_IN_WIDTH, 8, client tag width; output tag width is TAG_IN_WIDTH + SEL_BITS, where SEL_BITS = CLOG2(NUM_REQS), or 0 when NUM_REQS=1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid_in / req_rw_in  in  [NUM_REQS][NUM_LANES]  per-lane valid / write flag
- req_addr_in, req_byteen_in, req_data_in, req_tag_in  in  [NUM_REQS][NUM_LANES][*]  per-lane payload
- req_ready_in  out  [NUM_REQS][NUM_LANES]  per-lane accept, back to clients
- req_valid_out, req_rw_out, req_addr_out, req_byteen_out, req_data_out  out  [NUM_LANES][*]  to D$
- req_tag_out  out  [NUM_LANES][TAG_IN_WIDTH+SEL_BITS]  {client tag, client index}
- req_ready_out  in  [NUM_LANES]  D$ per-lane ready
- rsp_valid_in  in  1 ; rsp_tmask_in  in  NUM_LANES ; rsp_data_in  in  [NUM_LANES][DATA_WIDTH] ; rsp_tag_in  in  TAG_IN_WIDTH+SEL_BITS  (from D$)
- rsp_ready_in  out  1  to D$
- rsp_valid_out  out  NUM_REQS ; rsp_tmask_out, rsp_data_out, rsp_tag_out (TAG_IN_WIDTH)  out  shared ; rsp_ready_out  in  NUM_REQS

## Operation
- Client i is active when any bit of req_valid_in[i] is set.
- A client holds valid and payload on every lane that has not yet fired; it drops valid on a lane the cycle after that lane fires.
- State machine, IDLE / LOCKED:
  - IDLE: the grant is the first active client at or after rr_ptr, searching upward with wrap.
  - LOCKED: the grant is lock_idx, and no other client is considered.
- Lane fire, per lane: fire[l] = req_valid_out[l] & req_ready_out[l].
- Completion: the granted request completes when (req_valid_in[g] & ~fire) == 0.
  - IDLE, with a grant that completes in the same cycle: stay IDLE and set rr_ptr ← (g+1) mod NUM_REQS.
  - IDLE, with a grant that does not complete: go to LOCKED and set lock_idx ← g.
  - LOCKED, on completion: go to IDLE and set rr_ptr ← (lock_idx+1) mod NUM_REQS.
- Request datapath, combinational from the grant:
  - req_valid_out = req_valid_in[g], all zero when nothing is granted;
  - req_ready_in[g] = req_ready_out, all other clients' ready = 0;
  - req_tag_out[l] = {req_tag_in[g][l], g}.
- Response datapath, combinational:
  - sel = rsp_tag_in[SEL_BITS-1:0];
  - rsp_valid_out[sel] = rsp_valid_in;
  - rsp_tag_out = rsp_tag_in >> SEL_BITS;
  - rsp_ready_in = rsp_ready_out[sel].
- NUM_REQS=1: pure pass-through. The state machine is removed and no tag bits are added.
- A response with sel ≥ NUM_REQS is illegal. Simulation asserts on it, and it is dropped with rsp_ready_in=1.

## Timing
- Zero-cycle latency in both directions; there are no pipeline registers. State is updated on the clock edge only.
- Reset clears the state to IDLE, rr_ptr=0 and lock_idx=0.
- While reset is high, every output is 0: req_valid_out, req_ready_in, rsp_valid_out, rsp_ready_in and the payloads.
- A reset asserted while LOCKED abandons the partial request; clients must also be reset.
- A client that becomes active while another client is LOCKED waits at least until the cycle after completion.
- Fairness: with all clients continuously active, each client receives exactly one grant per NUM_REQS completions.
- A response may arrive in the same cycle as a request grant; the two paths are independent.

## Structure
- Shared package VX_gpu_pkg: the SEL_BITS helper function and the arb_state_e enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module VX_rr_arbiter:
  - inputs: request vector and rr_ptr;
  - outputs: one-hot and encoded grant.
- The parent holds the lock state machine, rr_ptr and the payload muxes.

## Test plan
- Single client 0, all 4 lanes valid, ready_out=4'b1111 → fires in 1 cycle; tag_out = {tag,0}; rr_ptr=1; state stays IDLE.
- Client 0 with 4 lanes valid and client 1 also valid; ready_out=4'b0011, then 4'b1100 → client 0 is LOCKED for 2 cycles, and req_ready_in[1] stays 0 throughout. Client 1 is granted in cycle 3.
- Both clients continuously active with full readiness over 8 completions → grants alternate 0,1,0,1,…
- Responses with rsp_tag_in low bit = 1 and then = 0; rsp_ready_out[1]=0 → rsp_ready_in=0 for the first response. The second response reaches only client 0, with the tag shifted right by 1.
- Reset asserted while LOCKED → the next cycle shows IDLE, rr_ptr=0 and every output 0 during reset.
- NUM_REQS=1 build → req_tag_out == req_tag_in, and ready/valid pass through unchanged.
